// File: rtl/demux_sequencer.sv
// -----------------------------------------------------------------------------
// demux_sequencer
//
// Sequencing controller for a 1-to-2 demultiplexer. Words accepted on the A
// valid/ready stream are steered to channel B or channel C according to a
// routing mode (fixed B, fixed C, alternate per word, burst alternate).
// Each channel owns a one-word registered output stage with its own
// valid/ready handshake, and a per-channel delivery counter for debug.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   A_in, A_valid, A_ready   input word stream (A_ready is combinational)
//   Mode                     routing mode: 00 B, 01 C, 10 alternate, 11 burst
//   outB, outB_valid, outB_ready   channel B output stage
//   outC, outC_valid, outC_ready   channel C output stage
//   Select                   current route (0 = B, 1 = C)
//   B_count, C_count         delivered-word counters, wrap 255 -> 0
// -----------------------------------------------------------------------------
module demux_sequencer #(
  parameter int WIDTH = 2,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_in,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] outB,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [WIDTH-1:0] outC,
  output logic             outC_valid,
  input  logic             outC_ready,
  output logic             Select,
  output logic [7:0]       B_count,
  output logic [7:0]       C_count
);

  localparam int CW = $clog2(BURST);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    MODE_B     = 2'b00,
    MODE_C     = 2'b01,
    MODE_ALT   = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  logic          sel;
  logic [CW-1:0] cnt;
  mode_t         mode_q;

  logic          sel_n;
  logic [CW-1:0] cnt_n;
  logic          x_valid;
  logic          x_ready;
  logic          acc;

  assign Select = sel;

  // Only the selected channel gates acceptance; the other channel may be
  // full and stalled without blocking the stream (and vice versa: no bypass).
  assign x_valid = sel ? outC_valid : outB_valid;
  assign x_ready = sel ? outC_ready : outB_ready;
  assign A_ready = !rst && (!x_valid || x_ready);
  assign acc     = A_valid && A_ready;

  always_comb begin
    sel_n = sel;
    cnt_n = cnt;
    if (acc) begin
      case (mode_q)
        MODE_B:   sel_n = 1'b0;
        MODE_C:   sel_n = 1'b1;
        MODE_ALT: sel_n = !sel;
        default: begin
          if (cnt == LAST) begin
            cnt_n = '0;
            sel_n = !sel;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outB       <= '0;
      outB_valid <= 1'b0;
      outC       <= '0;
      outC_valid <= 1'b0;
      sel        <= 1'b0;
      cnt        <= '0;
      mode_q     <= MODE_B;
      B_count    <= 8'd0;
      C_count    <= 8'd0;
    end else begin
      // A load takes priority over a drain so that a same-cycle drain and
      // reload passes straight through without a bubble.
      if (acc && !sel) begin
        outB       <= A_in;
        outB_valid <= 1'b1;
      end else if (outB_valid && outB_ready) begin
        outB_valid <= 1'b0;
      end

      if (acc && sel) begin
        outC       <= A_in;
        outC_valid <= 1'b1;
      end else if (outC_valid && outC_ready) begin
        outC_valid <= 1'b0;
      end

      if (outB_valid && outB_ready) B_count <= B_count + 8'd1;
      if (outC_valid && outC_ready) C_count <= C_count + 8'd1;

      cnt <= cnt_n;

      // Mode is only re-latched on a burst boundary. Outside burst mode the
      // counter never leaves zero, so Mode is effectively sampled every cycle.
      if (cnt_n == '0) begin
        mode_q <= mode_t'(Mode);
        case (mode_t'(Mode))
          MODE_B:  sel <= 1'b0;
          MODE_C:  sel <= 1'b1;
          default: sel <= sel_n;
        endcase
      end else begin
        sel <= sel_n;
      end
    end
  end

endmodule

// File: tb/tb_demux_sequencer.sv
module tb_demux_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] A_in;
  logic       A_valid;
  logic       A_ready;
  logic [1:0] Mode;
  logic [1:0] outB;
  logic       outB_valid;
  logic       outB_ready;
  logic [1:0] outC;
  logic       outC_valid;
  logic       outC_ready;
  logic       Select;
  logic [7:0] B_count;
  logic [7:0] C_count;

  int checks   = 0;
  int failures = 0;
  int bcnt     = 0;   // expected B deliveries (mod 256)
  int ccnt     = 0;   // expected C deliveries (mod 256)

  demux_sequencer #(.WIDTH(2), .BURST(4)) dut (
    .clk(clk), .rst(rst),
    .A_in(A_in), .A_valid(A_valid), .A_ready(A_ready),
    .Mode(Mode),
    .outB(outB), .outB_valid(outB_valid), .outB_ready(outB_ready),
    .outC(outC), .outC_valid(outC_valid), .outC_ready(outC_ready),
    .Select(Select), .B_count(B_count), .C_count(C_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, confirm it will be accepted, then clock it in.
  task automatic send(input logic [1:0] d, input string tag);
    A_valid = 1'b1;
    A_in    = d;
    #1;
    chk({tag, "_a_ready"}, A_ready, 1);
    tick();
  endtask

  initial begin
    rst = 1'b1; A_in = 2'd0; A_valid = 1'b0; Mode = 2'b00;
    outB_ready = 1'b0; outC_ready = 1'b0;
    tick(); tick();

    // ---------------- reset values ----------------
    chk("rst_a_ready", A_ready, 0);
    chk("rst_outb_valid", outB_valid, 0);
    chk("rst_outc_valid", outC_valid, 0);
    chk("rst_select", Select, 0);
    rst = 1'b0;
    #1;
    chk("rel_a_ready", A_ready, 1);

    // ---------------- reset mid-burst ----------------
    Mode = 2'b11; tick();                 // mode_q = 11
    outB_ready = 1'b1;
    send(2'd3, "mr_w1");
    send(2'd2, "mr_w2");                  // cnt = 2, B holds 2, one B delivery
    A_valid = 1'b0; outB_ready = 1'b0;
    chk("mr_outb_pre", outB, 2);
    chk("mr_bcount_pre", B_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_outb", outB, 0);
    chk("mr_outb_valid", outB_valid, 0);
    chk("mr_bcount", B_count, 0);
    chk("mr_a_ready", A_ready, 0);
    chk("mr_select", Select, 0);
    tick();
    rst = 1'b0; Mode = 2'b00;
    #1;
    chk("mr_rel_select", Select, 0);
    chk("mr_rel_a_ready", A_ready, 1);
    tick();

    // ---------------- fixed B ----------------
    outB_ready = 1'b1; outC_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), "fb");
      chk("fb_outb", outB, i);
      chk("fb_outb_valid", outB_valid, 1);
      chk("fb_outc_valid", outC_valid, 0);
    end
    A_valid = 1'b0;
    tick();
    bcnt = 4;
    chk("fb_bcount", B_count, 4);
    chk("fb_drained", outB_valid, 0);
    Mode = 2'b01;
    tick();
    chk("fc_select", Select, 1);

    // ---------------- alternate per word ----------------
    Mode = 2'b00; tick();                 // route back to B
    Mode = 2'b10; tick();                 // mode_q = 10, sel = 0
    chk("alt_select0", Select, 0);
    send(2'd1, "alt1"); chk("alt1_outb", outB, 1); chk("alt1_sel", Select, 1);
    send(2'd2, "alt2"); chk("alt2_outc", outC, 2); chk("alt2_outc_v", outC_valid, 1);
    chk("alt2_outb_v", outB_valid, 0);
    send(2'd3, "alt3"); chk("alt3_outb", outB, 3);
    send(2'd0, "alt4"); chk("alt4_outc", outC, 0);
    A_valid = 1'b0;
    tick();
    bcnt += 2; ccnt += 2;
    chk("alt_bcount", B_count, bcnt);
    chk("alt_ccount", C_count, ccnt);

    // ---------------- burst alternate ----------------
    Mode = 2'b11; tick();                 // mode_q = 11, sel = 0, cnt = 0
    for (int i = 0; i < 8; i++) begin
      send(2'(i % 4), "bu");
      if (i < 4) begin
        chk("bu_outb", outB, i % 4);
        chk("bu_outb_v", outB_valid, 1);
      end else begin
        chk("bu_outc", outC, i % 4);
        chk("bu_outc_v", outC_valid, 1);
      end
      chk("bu_select", Select, (i >= 3 && i < 7) ? 1 : 0);
    end
    A_valid = 1'b0;
    tick();
    bcnt += 4; ccnt += 4;
    chk("bu_bcount", B_count, bcnt);
    chk("bu_ccount", C_count, ccnt);

    // Mode change to 00 mid-burst: burst finishes on B, then 5th word on B.
    send(2'd1, "bm1"); send(2'd2, "bm2");
    Mode = 2'b00;
    send(2'd3, "bm3"); chk("bm3_outb", outB, 3); chk("bm3_select", Select, 0);
    send(2'd0, "bm4"); chk("bm4_outb", outB, 0); chk("bm4_select", Select, 0);
    send(2'd2, "bm5"); chk("bm5_outb", outB, 2); chk("bm5_outc_v", outC_valid, 0);
    A_valid = 1'b0;
    tick();
    bcnt += 5;

    // Mode change to 01 mid-burst: words 3,4 must still go to B.
    Mode = 2'b11; tick();
    send(2'd1, "bn1"); send(2'd2, "bn2");
    Mode = 2'b01;
    send(2'd3, "bn3"); chk("bn3_outb", outB, 3); chk("bn3_select", Select, 0);
    send(2'd0, "bn4"); chk("bn4_outb", outB, 0); chk("bn4_select", Select, 1);
    chk("bn4_outc_v", outC_valid, 0);
    A_valid = 1'b0;
    tick();
    bcnt += 4;
    chk("bn_bcount", B_count, bcnt % 256);

    // ---------------- backpressure ----------------
    Mode = 2'b00; tick();
    Mode = 2'b10; tick();                 // mode_q = 10, sel = 0
    outC_ready = 1'b0;
    send(2'd1, "bp1");                    // -> B
    send(2'd2, "bp2");                    // -> C, stays held
    send(2'd3, "bp3");                    // -> B, sel = 1
    A_in = 2'd0;
    #1;
    chk("bp_stall_a_ready", A_ready, 0);
    tick();                               // B drains, C still stuck
    chk("bp_outb_v", outB_valid, 0);
    chk("bp_outc", outC, 2);
    chk("bp_stall2_a_ready", A_ready, 0);
    outC_ready = 1'b1;
    #1;
    chk("bp_release_a_ready", A_ready, 1);
    tick();
    chk("bp_pass_outc", outC, 0);
    chk("bp_pass_outc_v", outC_valid, 1);
    chk("bp_select", Select, 0);
    A_valid = 1'b0;
    tick();
    bcnt += 2; ccnt += 2;
    chk("bp_bcount", B_count, bcnt % 256);
    chk("bp_ccount", C_count, ccnt % 256);

    // ---------------- counter wrap ----------------
    Mode = 2'b00; tick();
    for (int i = bcnt % 256; i < 256; i++) send(2'(i), "wr");
    A_valid = 1'b0;
    tick();
    chk("wrap_bcount", B_count, 0);

    // Load both channels with readies low, then release both together.
    outB_ready = 1'b0; outC_ready = 1'b0;
    Mode = 2'b10; tick();
    send(2'd1, "sim1");
    send(2'd2, "sim2");
    A_valid = 1'b0;
    chk("sim_outb_v", outB_valid, 1);
    chk("sim_outc_v", outC_valid, 1);
    outB_ready = 1'b1; outC_ready = 1'b1;
    tick();
    chk("sim_bcount", B_count, 1);
    chk("sim_ccount", C_count, (ccnt + 1) % 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_sequencer.md
# demux_sequencer

Sequencing controller for the 1-to-2 demultiplexer datapath. Accepts a valid/ready word stream on the A side and steers each accepted word to output channel B or C according to a routing mode: fixed B, fixed C, per-word alternate, or burst alternate. Each channel has a one-word registered output stage with its own valid/ready handshake. Per-channel transfer counters support debug. The block sits between a single producer and two downstream consumers.

## Interface
- WIDTH, 2, data word width
- BURST, 4, words per channel before switching in burst mode; legal range 2..256
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A_in  input  WIDTH  input data word
- A_valid  input  1  A_in holds a word
- A_ready  output  1  block accepts A_in this cycle
- Mode  input  2  routing mode: 00 fixed B, 01 fixed C, 10 alternate per word, 11 burst alternate
- outB  output  WIDTH  channel B data
- outB_valid  output  1  outB holds a word
- outB_ready  input  1  channel B consumer takes the word
- outC  output  WIDTH  channel C data
- outC_valid  output  1  outC holds a word
- outC_ready  input  1  channel C consumer takes the word
- Select  output  1  current route: 0 = B, 1 = C
- B_count  output  8  words delivered on B (outB_valid & outB_ready), wraps 255->0
- C_count  output  8  words delivered on C, wraps 255->0

## Operation
- Internal state: sel (drives Select), burst counter cnt (clog2(BURST) bits), latched mode mode_q, and two output registers with valid flags.
- Acceptance: acc = A_valid & A_ready. A_ready = !rst & (!X_valid | X_ready), where X is the channel chosen by sel. Combinational from sel and the selected channel's valid/ready only.
- On acc, A_in loads into the selected channel register and its valid is set. Otherwise the channel's valid clears when valid & ready. The non-selected channel is unaffected and drains independently.
- Route update on acc under mode_q:
  - 00: sel_n = 0.
  - 01: sel_n = 1.
  - 10: sel_n = !sel.
  - 11: cnt_n = cnt + 1. When cnt == BURST-1, cnt_n = 0 and sel_n = !sel.
  - With no acc, sel_n = sel and cnt_n = cnt.
- Mode latch happens only at a burst boundary, when cnt_n == 0. In that case mode_q <= Mode.
  - If Mode is 00, sel <= 0. If Mode is 01, sel <= 1.
  - If Mode is 10 or 11, sel <= sel_n.
  - When cnt_n != 0, sel <= sel_n and mode_q holds. A Mode change during a burst therefore waits until the burst completes.
- In modes 00, 01 and 10, cnt stays 0, so Mode is re-sampled every cycle.
- B_count and C_count increment on the respective output handshake. Both may increment in the same cycle.
- Reset values: outB = 0, outC = 0, outB_valid = 0, outC_valid = 0, Select = 0, cnt = 0, mode_q = 00, B_count = 0, C_count = 0. A_ready is 0 while rst is high.
- Reset asserted mid-burst discards both held words and the burst position, with no handshake completing.

## Timing
- Latency: a word accepted on edge N is visible on outX with outX_valid = 1 after edge N.
- Throughput: one word per cycle when the selected consumer holds ready high. A same-cycle drain and reload of a channel is a pass-through and must not produce a bubble.
- Stall: if the selected channel is full and its ready is low, A_ready = 0 even when the other channel is empty. There is no head-of-line bypass.
- Select and mode changes take effect on the edge after the accepting cycle. A_ready in the next cycle uses the new sel.
- Mode is sampled synchronously. Its setup is relative to clk only.
- All outputs are registered except A_ready.

## Test plan
- Reset: assert rst mid-stream with outB_valid = 1 and cnt = 2 -> all outputs read 0 immediately and A_ready = 0. After release, Select = 0 and A_ready = 1.
- Fixed modes: Mode = 00, send 0,1,2,3 with outB_ready = 1 -> B receives 0,1,2,3 one cycle after each accept, B_count = 4, outC_valid stays 0. Then Mode = 01 -> Select = 1 on the next edge.
- Alternate: Mode = 10, both readies = 1, stream 1,2,3,0 -> B gets 1,3 and C gets 2,0. A_ready stays 1 every cycle; B_count = 2, C_count = 2.
- Burst with BURST = 4: Mode = 11, send 8 words -> first 4 on B, next 4 on C. Mode switched to 00 after the 2nd word -> burst still finishes on B, then Select = 0 with mode 00 and the 5th word goes to B.
- Backpressure: Mode = 10, outC_ready = 0, C holds a word, sel = 1 -> A_ready = 0 while B is empty. Raising outC_ready -> same-cycle drain and accept, and outC shows the new word with no idle cycle.
- Counter wrap: 256 delivered words on B -> B_count = 0. Simultaneous B and C handshakes -> both counters increment in that cycle.
